// File: rtl/transfer_scheduler_if.sv
// ---------------------------------------------------------------------------
// transfer_scheduler_if
//
// Purpose : groups the data-path signals between the transfer scheduler, its
//           input FIFO (first-word-fall-through) and the four output FIFOs.
//
// Signals :
//   in_empty        input FIFO empty flag
//   in_data[11:0]   head word of the input FIFO; destination port = in_data[9:8]
//   in_pop          scheduler consumes the head word on this rising edge
//   fill_P0..P3     occupancy of output FIFOs 0..3 (depth 8, values 0..8)
//   out_push[3:0]   one-hot write strobe, one bit per output FIFO
//   out_data[11:0]  word written to the FIFO selected by out_push
//
// Modports:
//   master  scheduler side (drives in_pop, out_push, out_data)
//   slave   FIFO/environment side
// ---------------------------------------------------------------------------
interface transfer_scheduler_if;
    logic        in_empty;
    logic [11:0] in_data;
    logic        in_pop;
    logic [3:0]  fill_P0;
    logic [3:0]  fill_P1;
    logic [3:0]  fill_P2;
    logic [3:0]  fill_P3;
    logic [3:0]  out_push;
    logic [11:0] out_data;

    modport master (
        input  in_empty,
        input  in_data,
        input  fill_P0,
        input  fill_P1,
        input  fill_P2,
        input  fill_P3,
        output in_pop,
        output out_push,
        output out_data
    );

    modport slave (
        output in_empty,
        output in_data,
        output fill_P0,
        output fill_P1,
        output fill_P2,
        output fill_P3,
        input  in_pop,
        input  out_push,
        input  out_data
    );
endinterface

// File: rtl/transfer_scheduler.sv
// ---------------------------------------------------------------------------
// transfer_scheduler
//
// Purpose : moves words from one FWFT input FIFO to four output FIFOs. The
//           destination is in_data[9:8]. Each output port has a hysteresis
//           block flag (set at >= Umbral_alto, cleared at <= Umbral_bajo) and
//           a blocked head stalls all traffic (no reordering). Per-port 5-bit
//           sent counters can be read back through req/idx.
//
// Ports :
//   clk                       rising-edge clock
//   reset                     asynchronous, active-low
//   init                      1 = enter/hold INIT and load thresholds
//   Umbral_alto, Umbral_bajo  almost-full / release thresholds (words)
//   bus                       transfer_scheduler_if.master (FIFO data path)
//   req, idx                  counter read request and index
//   counterValid, counterOut  read response, one cycle after req
//   state                     FSM state (RESET=00, INIT=01, IDLE=10, ACTIVE=11)
//   idle                      1 in IDLE while the input FIFO is empty
//
// Handshake : in_pop is an acknowledge for the head word; the word is
//   consumed on the rising edge where in_pop=1 (only ever with in_empty=0).
//   out_push is a valid-only strobe with no back-pressure: the scheduler never
//   pushes to a port whose block flag is set, and the word appears on
//   out_data exactly one cycle after its pop.
//
// Configuration : define TL_STALL_COUNT_EN to add a saturating stall counter
//   (ACTIVE cycles with a head word present but no pop), read at idx=5.
//   Without it idx=5 reads 0.
// ---------------------------------------------------------------------------
module transfer_scheduler (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        init,
    input  logic [2:0]                  Umbral_alto,
    input  logic [2:0]                  Umbral_bajo,
    transfer_scheduler_if.master        bus,
    input  logic                        req,
    input  logic [2:0]                  idx,
    output logic                        counterValid,
    output logic [4:0]                  counterOut,
    output logic [1:0]                  state,
    output logic                        idle
);

    typedef enum logic [1:0] {
        ST_RESET  = 2'b00,
        ST_INIT   = 2'b01,
        ST_IDLE   = 2'b10,
        ST_ACTIVE = 2'b11
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic [2:0]  alto_q;
    logic [2:0]  bajo_q;
    logic [3:0]  blocked_q;
    logic [3:0]  blocked_d;
    logic [3:0]  out_push_q;
    logic [11:0] out_data_q;
    logic [4:0]  cnt_q [4];
    logic [4:0]  cnt_sum;
    logic [4:0]  rd_val;
    logic [4:0]  stall_val;
    logic        pop;
    logic        idle_c;
    logic [1:0]  dest;
    logic [3:0]  fill [4];
    logic [4:0]  eff_fill [4];

    assign dest    = bus.in_data[9:8];
    assign fill[0] = bus.fill_P0;
    assign fill[1] = bus.fill_P1;
    assign fill[2] = bus.fill_P2;
    assign fill[3] = bus.fill_P3;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        if (init) begin
            state_d = ST_INIT;
        end else begin
            case (state_q)
                ST_RESET:  state_d = ST_INIT;
                ST_INIT:   state_d = ST_IDLE;
                ST_IDLE:   if (!bus.in_empty) state_d = ST_ACTIVE;
                ST_ACTIVE: if (bus.in_empty && !pop) state_d = ST_IDLE;
                default:   state_d = ST_RESET;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    // Pop decision uses the registered block flags, so a port that just
    // crossed Umbral_alto is still served for the cycle in which it crossed.
    always_comb begin
        pop    = 1'b0;
        idle_c = 1'b0;
        case (state_q)
            ST_IDLE:   idle_c = bus.in_empty;
            ST_ACTIVE: pop    = !bus.in_empty && !blocked_q[dest];
            default:   ;
        endcase
    end

    assign bus.in_pop = pop;
    assign idle       = idle_c;
    assign state      = state_q;

    // ---------------- thresholds ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alto_q <= 3'd0;
            bajo_q <= 3'd0;
        end else if (init) begin
            alto_q <= Umbral_alto;
            bajo_q <= Umbral_bajo;
        end
    end

    // ---------------- block flags (hysteresis) ----------------
    // The word being pushed this cycle is not yet in fill_Pp, so it is added
    // here to avoid under-counting the FIFO occupancy by one.
    always_comb begin
        for (int p = 0; p < 4; p++) begin
            eff_fill[p]  = {1'b0, fill[p]} + {4'b0000, out_push_q[p]};
            blocked_d[p] = blocked_q[p];
            if (eff_fill[p] >= {2'b00, alto_q}) begin
                blocked_d[p] = 1'b1;
            end else if (eff_fill[p] <= {2'b00, bajo_q}) begin
                blocked_d[p] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blocked_q <= 4'b0000;
        end else if (state_q == ST_INIT) begin
            blocked_q <= 4'b0000;
        end else begin
            blocked_q <= blocked_d;
        end
    end

    // ---------------- output register (1-cycle latency) ----------------
    // Not gated by state: a word popped just before init still gets pushed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_push_q <= 4'b0000;
            out_data_q <= 12'h000;
        end else if (pop) begin
            out_push_q <= 4'b0001 << dest;
            out_data_q <= bus.in_data;
        end else begin
            out_push_q <= 4'b0000;
            out_data_q <= 12'h000;
        end
    end

    assign bus.out_push = out_push_q;
    assign bus.out_data = out_data_q;

    // ---------------- per-port sent counters (wrap at 32) ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int p = 0; p < 4; p++) cnt_q[p] <= 5'd0;
        end else if (state_q == ST_INIT) begin
            for (int p = 0; p < 4; p++) cnt_q[p] <= 5'd0;
        end else begin
            for (int p = 0; p < 4; p++) begin
                if (out_push_q[p]) cnt_q[p] <= cnt_q[p] + 5'd1;
            end
        end
    end

    assign cnt_sum = cnt_q[0] + cnt_q[1] + cnt_q[2] + cnt_q[3];

`ifdef TL_STALL_COUNT_EN
    logic [4:0] stall_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q <= 5'd0;
        end else if (state_q == ST_INIT) begin
            stall_q <= 5'd0;
        end else if (state_q == ST_ACTIVE && !bus.in_empty && !pop &&
                     stall_q != 5'd31) begin
            stall_q <= stall_q + 5'd1;
        end
    end

    assign stall_val = stall_q;
`else
    assign stall_val = 5'd0;
`endif

    // ---------------- counter read port ----------------
    // Samples the counters before this edge's increment, so a read that
    // coincides with a push returns the pre-increment value.
    always_comb begin
        rd_val = 5'd0;
        case (idx)
            3'd0:    rd_val = cnt_q[0];
            3'd1:    rd_val = cnt_q[1];
            3'd2:    rd_val = cnt_q[2];
            3'd3:    rd_val = cnt_q[3];
            3'd4:    rd_val = cnt_sum;
            3'd5:    rd_val = stall_val;
            default: rd_val = 5'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            counterValid <= 1'b0;
            counterOut   <= 5'd0;
        end else if (req) begin
            counterValid <= 1'b1;
            counterOut   <= rd_val;
        end else begin
            counterValid <= 1'b0;
            counterOut   <= 5'd0;
        end
    end

endmodule

// File: tb/tb_transfer_scheduler.sv
// ---------------------------------------------------------------------------
// tb_transfer_scheduler
//
// Drives the scheduler from a queue standing in for the input FIFO and keeps
// a behavioural model of the expected outputs (state, pops, pushes, counters)
// computed from the block's rules with plain integers and arrays. Directed
// scenarios cover the documented cases, then a randomized phase follows.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_transfer_scheduler;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        init;
    logic [2:0]  alto;
    logic [2:0]  bajo;
    logic        req;
    logic [2:0]  idx;
    logic        counterValid;
    logic [4:0]  counterOut;
    logic [1:0]  state;
    logic        idle;

    transfer_scheduler_if bus ();

    transfer_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .init         (init),
        .Umbral_alto  (alto),
        .Umbral_bajo  (bajo),
        .bus          (bus),
        .req          (req),
        .idx          (idx),
        .counterValid (counterValid),
        .counterOut   (counterOut),
        .state        (state),
        .idle         (idle)
    );

    // ---------------- bench state ----------------
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [11:0] fifo_q[$];     // input FIFO contents, head at index 0
    logic [11:0] exp_q[$];      // popped words awaiting their push
    int          fill [4];

    // reference model
    int          m_state;       // 0 RESET, 1 INIT, 2 IDLE, 3 ACTIVE
    int          m_alto;
    int          m_bajo;
    bit          m_blk [4];
    int          m_cnt [4];
    int          m_stall;
    logic [3:0]  m_push;
    bit          m_cv;
    int          m_co;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_pins();
        bus.in_empty = (fifo_q.size() == 0);
        bus.in_data  = (fifo_q.size() > 0) ? fifo_q[0] : 12'h000;
        bus.fill_P0  = 4'(fill[0]);
        bus.fill_P1  = 4'(fill[1]);
        bus.fill_P2  = 4'(fill[2]);
        bus.fill_P3  = 4'(fill[3]);
    endtask

    task automatic model_reset();
        m_state = 0;
        m_alto  = 0;
        m_bajo  = 0;
        m_stall = 0;
        m_push  = 4'b0000;
        m_cv    = 1'b0;
        m_co    = 0;
        for (int p = 0; p < 4; p++) begin
            m_blk[p] = 1'b0;
            m_cnt[p] = 0;
        end
        exp_q.delete();
    endtask

    // One clock cycle: check outputs at the falling edge against the model,
    // work out what the model holds after the next rising edge, then apply it.
    task automatic step();
        bit          nonempty;
        bit          e_pop;
        int          dest;
        int          eff;
        int          rd;
        int          n_state;
        int          n_stall;
        bit          n_blk [4];
        int          n_cnt [4];
        logic [3:0]  n_push;
        logic [11:0] head;

        @(negedge clk);
        nonempty = (fifo_q.size() > 0);
        head     = nonempty ? fifo_q[0] : 12'h000;
        dest     = int'(head[9:8]);
        e_pop    = (m_state == 3) && nonempty && !m_blk[dest];

        check("state", 32'(state), 32'(m_state));
        check("in_pop", 32'(bus.in_pop), 32'(e_pop));
        check("idle", 32'(idle), 32'((m_state == 2) && !nonempty));
        check("out_push", 32'(bus.out_push), 32'(m_push));
        if (m_push != 4'b0000 && exp_q.size() > 0)
            check("out_data", 32'(bus.out_data), 32'(exp_q.pop_front()));
        check("counterValid", 32'(counterValid), 32'(m_cv));
        check("counterOut", 32'(counterOut), 32'(m_co));

        if (!reset) begin
            @(posedge clk);
            #1;
            model_reset();
            drive_pins();
            return;
        end

        // counter read (pre-increment values)
        case (idx)
            3'd0, 3'd1, 3'd2, 3'd3: rd = m_cnt[idx];
            3'd4:    rd = (m_cnt[0] + m_cnt[1] + m_cnt[2] + m_cnt[3]) % 32;
`ifdef TL_STALL_COUNT_EN
            3'd5:    rd = m_stall;
`else
            3'd5:    rd = 0;
`endif
            default: rd = 0;
        endcase

        for (int p = 0; p < 4; p++) begin
            eff = fill[p] + (m_push[p] ? 1 : 0);
            if (m_state == 1)       n_blk[p] = 1'b0;
            else if (eff >= m_alto) n_blk[p] = 1'b1;
            else if (eff <= m_bajo) n_blk[p] = 1'b0;
            else                    n_blk[p] = m_blk[p];
            if (m_state == 1) n_cnt[p] = 0;
            else              n_cnt[p] = (m_cnt[p] + (m_push[p] ? 1 : 0)) % 32;
        end

        if (m_state == 1)
            n_stall = 0;
        else if (m_state == 3 && nonempty && !e_pop && m_stall < 31)
            n_stall = m_stall + 1;
        else
            n_stall = m_stall;

        if (init)               n_state = 1;
        else if (m_state == 0)  n_state = 1;
        else if (m_state == 1)  n_state = 2;
        else if (m_state == 2)  n_state = nonempty ? 3 : 2;
        else                    n_state = nonempty ? 3 : 2;

        n_push = 4'b0000;
        if (e_pop) begin
            n_push = 4'b0001 << dest;
            exp_q.push_back(head);
        end

        @(posedge clk);
        #1;
        if (init) begin
            m_alto = int'(alto);
            m_bajo = int'(bajo);
        end
        m_state = n_state;
        m_stall = n_stall;
        m_push  = n_push;
        m_cv    = req;
        m_co    = req ? rd : 0;
        for (int p = 0; p < 4; p++) begin
            m_blk[p] = n_blk[p];
            m_cnt[p] = n_cnt[p];
        end
        if (e_pop) void'(fifo_q.pop_front());
        drive_pins();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // init pulse from IDLE/ACTIVE: one cycle loading, one cycle into IDLE
    task automatic do_init(input int a, input int b);
        init = 1'b1;
        alto = 3'(a);
        bajo = 3'(b);
        step();
        init = 1'b0;
        step();
    endtask

    task automatic read_cnt(input int i, output logic [4:0] v);
        req = 1'b1;
        idx = 3'(i);
        step();
        req = 1'b0;
        idx = 3'd0;
        v   = counterOut;
    endtask

    task automatic push_word(input logic [11:0] w);
        fifo_q.push_back(w);
        drive_pins();
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [4:0] v;
        int         exp_stall;

        reset = 1'b0;
        init  = 1'b0;
        alto  = 3'd0;
        bajo  = 3'd0;
        req   = 1'b0;
        idx   = 3'd0;
        for (int p = 0; p < 4; p++) fill[p] = 0;
        model_reset();
        drive_pins();

        // reset, then init with alto=6 bajo=0
        run(2);
        check("rst_state", 32'(state), 32'd0);
        reset = 1'b1;
        init  = 1'b1;
        alto  = 3'd6;
        bajo  = 3'd0;
        step();
        check("init_state", 32'(state), 32'd1);
        step();
        init = 1'b0;
        step();
        check("idle_state", 32'(state), 32'd2);
        check("idle_flag", 32'(idle), 32'd1);

        // three words to port 1
        push_word(12'h100);
        push_word(12'h101);
        push_word(12'h102);
        run(5);
        read_cnt(1, v);
        check("cnt_p1", 32'(v), 32'd3);
        read_cnt(4, v);
        check("cnt_sum", 32'(v), 32'd3);

        // hysteresis on port 0: alto=5 bajo=1
        do_init(5, 1);
        fill[0] = 5;
        drive_pins();
        run(1);
        push_word(12'h0A5);
        run(10);
        check("blk_hold", 32'(bus.in_pop), 32'd0);
        fill[0] = 2;
        drive_pins();
        run(5);
        check("blk_hyst", 32'(bus.in_pop), 32'd0);
        fill[0] = 1;
        drive_pins();
        run(1);
        check("blk_release", 32'(bus.in_pop), 32'd1);
        run(3);

        // head-of-line blocking: port 2 full, port 3 free behind it
        do_init(5, 1);
        fill[2] = 8;
        drive_pins();
        run(1);
        push_word(12'h2AA);
        push_word(12'h3BB);
        run(8);
        check("hol_stall", 32'(bus.in_pop), 32'd0);
        fill[2] = 0;
        drive_pins();
        run(6);

        // alto=0 blocks everything
        do_init(0, 0);
        push_word(12'h011);
        push_word(12'h122);
        run(10);
        check("alto0_block", 32'(bus.in_pop), 32'd0);
        do_init(6, 0);
        run(6);

        // 33 pushes to port 0, with a read in the middle of the burst
        do_init(6, 0);
        for (int i = 0; i < 33; i++) push_word({4'h0, 8'(i)});
        run(16);
        req = 1'b1;
        idx = 3'd0;
        step();
        req = 1'b0;
        run(25);
        read_cnt(0, v);
        check("cnt_wrap", 32'(v), 32'd1);

        // stall counter: port 1 blocked for 40 cycles
        do_init(6, 0);
        fill[1] = 8;
        drive_pins();
        run(1);
        push_word(12'h1C3);
        run(41);
        read_cnt(5, v);
`ifdef TL_STALL_COUNT_EN
        exp_stall = 31;
`else
        exp_stall = 0;
`endif
        check("stall_cnt", 32'(v), 32'(exp_stall));
        fill[1] = 0;
        drive_pins();
        run(4);

        // reset while a word is in flight
        do_init(6, 0);
        push_word(12'h155);
        run(2);
        reset = 1'b0;
        #1;
        check("rst_push", 32'(bus.out_push), 32'd0);
        check("rst_data", 32'(bus.out_data), 32'd0);
        check("rst_st", 32'(state), 32'd0);
        model_reset();
        run(2);
        reset = 1'b1;
        init  = 1'b1;
        alto  = 3'd6;
        bajo  = 3'd0;
        run(2);
        init = 1'b0;
        run(4);

        // randomized traffic, two threshold settings
        for (int r = 0; r < 2; r++) begin
            int a;
            a = int'($urandom_range(1, 7));
            do_init(a, int'($urandom_range(0, a - 1)));
            for (int c = 0; c < 300; c++) begin
                if (fifo_q.size() < 6 && $urandom_range(0, 2) == 0)
                    fifo_q.push_back(12'($urandom_range(0, 4095)));
                if ($urandom_range(0, 7) == 0)
                    fill[$urandom_range(0, 3)] = int'($urandom_range(0, 8));
                req = 1'($urandom_range(0, 1));
                idx = 3'($urandom_range(0, 7));
                drive_pins();
                step();
            end
            req = 1'b0;
            for (int p = 0; p < 4; p++) fill[p] = 0;
            drive_pins();
            run(12);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/transfer_scheduler.md
TRANSFER_SCHEDULER -- requirements
Module: transfer_scheduler

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have: reset  in  1  asynchronous, active-low; 0 = reset asserted.
REQ-003 SHALL have: init  in  1  synchronous; 1 = enter/hold INIT, load thresholds.
REQ-004 SHALL have: Umbral_alto, Umbral_bajo  in  3 each  almost-full / release thresholds (words).
REQ-005 SHALL have: in_empty  in  1; in_data  in  12  head word of input FIFO, first-word-fall-through; destination = in_data[9:8].
REQ-006 SHALL have: fill_P0..fill_P3  in  4 each  current occupancy of output FIFOs (depth 8).
REQ-007 SHALL have: in_pop  out  1; out_push  out  4  one-hot per port; out_data  out  12.
REQ-008 SHALL have: req  in  1; idx  in  3; counterValid  out  1; counterOut  out  5.
REQ-009 SHALL have: state  out  2  (RESET=00, INIT=01, IDLE=10, ACTIVE=11); idle  out  1  (1 in IDLE with in_empty=1).

Function
REQ-010 FSM SHALL go RESET->INIT on first clock after reset release.
REQ-011 INIT: thresholds SHALL be registered every cycle init=1; counters and block flags cleared; init=0 -> IDLE.
REQ-012 init=1 in any state SHALL force INIT next cycle, discarding no already-pushed word.
REQ-013 IDLE: in_empty=0 -> ACTIVE; ACTIVE: in_empty=1 with no pop this cycle -> IDLE.
REQ-014 Effective fill for port p SHALL be fill_Pp + 1 if out_push[p] is high this cycle, else fill_Pp.
REQ-015 Port block flag SHALL set when effective fill >= Umbral_alto_reg, clear when effective fill <= Umbral_bajo_reg (hysteresis); set wins if both true.
REQ-016 ACTIVE: in_pop SHALL assert combinationally when in_empty=0 and destination port unblocked; at most one pop per cycle.
REQ-017 A popped word SHALL appear on out_data with out_push[dest] one cycle later (1-cycle latency); out_push=0 otherwise.
REQ-018 Blocked head SHALL stall all traffic (head-of-line blocking, no reordering).
REQ-019 Umbral_alto_reg=0 SHALL block every port permanently (no traffic).
REQ-020 Per-port 5-bit sent counter SHALL increment on each out_push[p], wrapping 31->0.
REQ-021 Read: with req=1, next cycle counterValid=1, counterOut = count[idx] for idx 0..3, sum of all four (mod 32) for idx=4, 0 for idx 6..7 (and idx 5 per REQ-026).
REQ-022 req=0 SHALL drive counterValid=0, counterOut=0 next cycle.
REQ-023 Read coincident with a push SHALL return pre-increment value.

Reset
REQ-024 reset=0 SHALL immediately force: state=RESET, in_pop=0, out_push=0, out_data=0, counterValid=0, counterOut=0, idle=0, thresholds=0, all counters and block flags 0.
REQ-025 Reset mid-transfer SHALL drop the in-flight registered word (no push after release).

Configuration
REQ-026 With TL_STALL_COUNT_EN defined: 5-bit saturating counter (max 31) SHALL count ACTIVE cycles with in_empty=0 and in_pop=0, cleared in INIT, read at idx=5; without it: no counter, idx=5 reads 0.

Verification
REQ-027 reset low 2 cycles, init=1 with alto=6,bajo=0, init=0 -> state 00,01,10; idle=1.
REQ-028 Push 3 words dest 1 (in_data=0x100,0x101,0x102), fills 0 -> out_push=0010 three consecutive cycles after pops; req, idx=1 -> counterOut=3, idx=4 -> 3.
REQ-029 alto=5, bajo=1, fill_P0 held 5, head dest 0 -> in_pop=0 indefinitely; drop fill_P0 to 2 -> still blocked; fill_P0=1 -> pop next cycle.
REQ-030 Head dest 2 blocked, next word dest 3 free -> no pop of either until port 2 released (order preserved).
REQ-031 33 pushes to port 0 -> count[0]=1 (wrap); read during push returns old value.
REQ-032 TL_STALL_COUNT_EN: 40 blocked cycles -> idx=5 reads 31; undefined -> reads 0.
